// File: rtl/fp_resize_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_resize_stream_if
// Description : Stream bundle for fp_resize_stream. Carries the input beat
//               (valid/ready, packed lane data, per-beat rounding mode and
//               saturate enable) and the output beat (valid/ready, packed
//               lane data, per-lane clip flags).
//
//               master : the side that produces input beats and consumes
//                        output beats (upstream/downstream environment).
//               slave  : the converter itself.
//
//               Parameters
//                 LANES : lanes per beat
//                 IW    : input lane width  (IN_IW + IN_QW)
//                 OW    : output lane width (OUT_IW + OUT_QW)
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_resize_stream_if #(
    parameter int LANES = 1,
    parameter int IW    = 32,
    parameter int OW    = 16
);
    // Input beat
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*IW-1:0]   in_data;
    logic [1:0]            in_rnd_mode;
    logic                  in_sat_en;

    // Output beat
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*OW-1:0]   out_data;
    logic [LANES-1:0]      out_clip;

    modport master (
        output in_valid,
        output in_data,
        output in_rnd_mode,
        output in_sat_en,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_clip,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_rnd_mode,
        input  in_sat_en,
        output in_ready,
        output out_valid,
        output out_data,
        output out_clip,
        input  out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fp_resize_stream.sv
`default_nettype none
// ============================================================================
// Module      : fp_resize_stream
// Description : Streaming multi-lane signed fixed-point format converter.
//               Each lane converts Q(IN_IW).(IN_QW) two's complement to
//               Q(OUT_IW).(OUT_QW). Two-stage valid/ready pipeline:
//                 stage 1 : align to the output binary point and round
//                           (floor / half-up / half-even, chosen per beat)
//                 stage 2 : range check, clamp or wrap, per-lane clip flag
//               A saturating 16-bit counter accumulates clipped lanes on
//               every output handshake.
//
// Ports
//   clk            in   clock, all state on the rising edge
//   rst_n          in   asynchronous active-low reset
//   bus (slave)         in_valid/in_ready/in_data/in_rnd_mode/in_sat_en,
//                       out_valid/out_ready/out_data/out_clip
//   clip_clr       in   synchronous clear of clip_count (wins over update)
//   clip_count     out  saturating count of clipped lanes
//
// Revision    : 1.0 - initial release
// ============================================================================
module fp_resize_stream #(
    parameter int IN_IW  = 16,
    parameter int IN_QW  = 16,
    parameter int OUT_IW = 8,
    parameter int OUT_QW = 8,
    parameter int LANES  = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fp_resize_stream_if.slave  bus,
    input  wire logic          clip_clr,
    output logic [15:0]        clip_count
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    localparam int IW  = IN_IW + IN_QW;
    localparam int OW  = OUT_IW + OUT_QW;
    localparam int D   = IN_QW - OUT_QW;
    localparam int SHR = (D > 0) ? D : 0;
    localparam int SHL = (D < 0) ? -D : 0;
    // Working width: wide enough for the left-shifted input and for the
    // output word, plus two guard bits so the rounding increment can never
    // overflow the intermediate value.
    localparam int WA  = IW + SHL;
    localparam int WW  = ((WA > OW) ? WA : OW) + 2;

    localparam logic [OW-1:0] SAT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] SAT_MIN = {1'b1, {(OW-1){1'b0}}};

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    logic                  s1_valid_q, s1_valid_d;
    logic [LANES*WW-1:0]   s1_val_q,   s1_val_d;
    logic                  s1_sat_q,   s1_sat_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [LANES*OW-1:0]   s2_data_q,  s2_data_d;
    logic [LANES-1:0]      s2_clip_q,  s2_clip_d;

    logic [15:0]           clip_count_q, clip_count_d;

    // Handshake / advance controls
    logic                  s1_load;
    logic                  s2_load;
    logic                  out_hs;

    // Per-lane combinational results gathered into packed vectors
    logic [LANES*WW-1:0]   rnd_all;
    logic [LANES*OW-1:0]   rng_data;
    logic [LANES-1:0]      rng_clip;

    // Clip counter arithmetic
    logic [16:0]           pop;
    logic [16:0]           sum;

    // ------------------------------------------------------------------------
    // Per-lane datapath
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [WW-1:0] lane_ext;
        logic signed [WW-1:0] lane_rnd;
        logic [WW-OW:0]       hi_bits;
        logic                 ovf;

        // Sign-extend the raw input lane into the working width.
        assign lane_ext = {{(WW-IW){bus.in_data[i*IW+IW-1]}}, bus.in_data[i*IW +: IW]};

        if (SHR == 0) begin : g_widen
            // Output has at least as many fraction bits: exact, no rounding.
            assign lane_rnd = lane_ext <<< SHL;
        end else begin : g_round
            // Bits strictly below the round bit; all-zero means an exact tie.
            localparam logic [WW-1:0] STICKY_MASK = (WW'(1) << (SHR-1)) - WW'(1);

            logic signed [WW-1:0] floor_v;
            logic                 round_bit;
            logic                 sticky;
            logic                 inc;

            assign floor_v   = lane_ext >>> SHR;
            assign round_bit = lane_ext[SHR-1];
            assign sticky    = |(lane_ext & STICKY_MASK);

            // Adding 2^(SHR-1) before the shift is the same as adding the
            // round bit after it. Half-even suppresses the increment only on
            // an exact tie whose kept LSB is already even.
            always_comb begin
                inc = 1'b0;
                case (bus.in_rnd_mode)
                    2'd1:    inc = round_bit;
                    2'd2:    inc = round_bit && (sticky || floor_v[0]);
                    default: inc = 1'b0;
                endcase
            end

            assign lane_rnd = floor_v + WW'(inc);
        end

        assign rnd_all[i*WW +: WW] = lane_rnd;

        // The registered value fits in OW signed bits exactly when every bit
        // from the output sign position upward agrees.
        assign hi_bits = s1_val_q[i*WW + OW - 1 +: WW - OW + 1];
        assign ovf     = !((&hi_bits) || !(|hi_bits));

        assign rng_clip[i]           = ovf;
        assign rng_data[i*OW +: OW]  = (ovf && s1_sat_q)
                                       ? (s1_val_q[i*WW + WW - 1] ? SAT_MIN : SAT_MAX)
                                       : s1_val_q[i*WW +: OW];
    end

    // ------------------------------------------------------------------------
    // Pipeline control and next state
    // ------------------------------------------------------------------------
    always_comb begin
        // A stage may take new contents when it is empty or its contents
        // move on this cycle; this ripples back combinationally to in_ready.
        s2_load = !s2_valid_q || bus.out_ready;
        s1_load = !s1_valid_q || s2_load;
        out_hs  = s2_valid_q && bus.out_ready;

        s1_valid_d = s1_valid_q;
        s1_val_d   = s1_val_q;
        s1_sat_d   = s1_sat_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_clip_d  = s2_clip_q;

        if (s1_load) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_val_d = rnd_all;
                s1_sat_d = bus.in_sat_en;
            end
        end

        // Output data only changes when a new beat lands in stage 2, so it
        // stays frozen while the downstream stalls.
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = rng_data;
                s2_clip_d = rng_clip;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Clip event counter
    // ------------------------------------------------------------------------
    always_comb begin
        pop = '0;
        for (int k = 0; k < LANES; k++) begin
            pop = pop + 17'(s2_clip_q[k]);
        end
        sum = {1'b0, clip_count_q} + pop;

        clip_count_d = clip_count_q;
        if (clip_clr) begin
            // Clear wins, but a beat leaving on the same edge is still counted.
            clip_count_d = out_hs ? pop[15:0] : 16'h0000;
        end else if (out_hs) begin
            clip_count_d = sum[16] ? 16'hFFFF : sum[15:0];
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_val_q     <= '0;
            s1_sat_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_clip_q    <= '0;
            clip_count_q <= 16'h0000;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_val_q     <= s1_val_d;
            s1_sat_q     <= s1_sat_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_clip_q    <= s2_clip_d;
            clip_count_q <= clip_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_clip  = s2_clip_q;
    assign clip_count    = clip_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_resize_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_resize_stream
// Description : Directed self-checking bench for fp_resize_stream. A one-lane
//               instance covers conversion, rounding, overflow, backpressure
//               and mid-stream reset; a four-lane instance covers the clip
//               counter, including clear priority and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_resize_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clip_clr1;
    logic        clip_clr4;
    logic [15:0] clip_count1;
    logic [15:0] clip_count4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp_resize_stream_if #(.LANES(1), .IW(32), .OW(16)) bus1 ();
    fp_resize_stream_if #(.LANES(4), .IW(32), .OW(16)) bus4 ();

    fp_resize_stream #(
        .IN_IW(16), .IN_QW(16), .OUT_IW(8), .OUT_QW(8), .LANES(1)
    ) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus1),
        .clip_clr   (clip_clr1),
        .clip_count (clip_count1)
    );

    fp_resize_stream #(
        .IN_IW(16), .IN_QW(16), .OUT_IW(8), .OUT_QW(8), .LANES(4)
    ) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus4),
        .clip_clr   (clip_clr4),
        .clip_count (clip_count4)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat on the single-lane instance with out_ready high.
    task automatic xfer1(input string tag, input logic [31:0] din, input logic [1:0] mode,
                         input logic sat, input logic [15:0] exp_d, input logic exp_c);
        bus1.in_valid    = 1'b1;
        bus1.in_data     = din;
        bus1.in_rnd_mode = mode;
        bus1.in_sat_en   = sat;
        tick();
        // Scramble the controls so a late capture would show up.
        bus1.in_valid    = 1'b0;
        bus1.in_data     = 32'hDEAD_BEEF;
        bus1.in_rnd_mode = mode ^ 2'd3;
        bus1.in_sat_en   = !sat;
        check_val({tag, "/early"}, 64'(bus1.out_valid), 64'd0);
        tick();
        check_val({tag, "/valid"}, 64'(bus1.out_valid), 64'd1);
        check_val({tag, "/data"},  64'(bus1.out_data),  64'(exp_d));
        check_val({tag, "/clip"},  64'(bus1.out_clip),  64'(exp_c));
    endtask

    function automatic logic [127:0] beat4(input logic [3:0] m);
        logic [127:0] b;
        for (int k = 0; k < 4; k++) b[k*32 +: 32] = m[k] ? 32'h0080_0000 : 32'h0001_0000;
        return b;
    endfunction

    task automatic send4(input logic [3:0] m);
        bus4.in_valid = 1'b1;
        bus4.in_data  = beat4(m);
        tick();
        bus4.in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int   sent;
        int   rcvd;
        int   cyc;
        logic m_s1;
        logic m_s2;
        logic s1l;
        logic s2l;
        logic have_hold;
        logic [15:0] held;

        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_rnd_mode = 2'd0;
        bus1.in_sat_en = 1'b1; bus1.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_rnd_mode = 2'd0;
        bus4.in_sat_en = 1'b1; bus4.out_ready = 1'b1;
        clip_clr1 = 1'b0; clip_clr4 = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst/out_valid",  64'(bus1.out_valid), 64'd0);
        check_val("rst/out_data",   64'(bus1.out_data),  64'd0);
        check_val("rst/out_clip",   64'(bus1.out_clip),  64'd0);
        check_val("rst/clip_count", 64'(clip_count1),    64'd0);
        rst_n = 1'b1;
        tick();
        check_val("rst/in_ready",   64'(bus1.in_ready),  64'd1);

        // Basic conversion
        xfer1("basic_pos", 32'h0001_8000, 2'd0, 1'b1, 16'h0180, 1'b0);
        xfer1("basic_neg", 32'hFFFE_8000, 2'd0, 1'b1, 16'hFE80, 1'b0);

        // Rounding ties
        xfer1("tie_m0",     32'h0000_0080, 2'd0, 1'b1, 16'h0000, 1'b0);
        xfer1("tie_m1",     32'h0000_0080, 2'd1, 1'b1, 16'h0001, 1'b0);
        xfer1("tie_m2",     32'h0000_0080, 2'd2, 1'b1, 16'h0000, 1'b0);
        xfer1("tie_odd_m2", 32'h0000_0180, 2'd2, 1'b1, 16'h0002, 1'b0);
        xfer1("ntie_m0",    32'hFFFF_FF80, 2'd0, 1'b1, 16'hFFFF, 1'b0);
        xfer1("ntie_m1",    32'hFFFF_FF80, 2'd1, 1'b1, 16'h0000, 1'b0);
        xfer1("ntie_m2",    32'hFFFF_FF80, 2'd2, 1'b1, 16'h0000, 1'b0);

        // Overflow
        xfer1("ovf_sat",    32'h0080_0000, 2'd0, 1'b1, 16'h7FFF, 1'b1);
        xfer1("ovf_wrap",   32'h0080_0000, 2'd0, 1'b0, 16'h8000, 1'b1);
        xfer1("ovf_neg",    32'hFF7F_0000, 2'd0, 1'b1, 16'h8000, 1'b1);
        xfer1("ovf_round",  32'h007F_FFFF, 2'd1, 1'b1, 16'h7FFF, 1'b1);

        // Drain, then the four clipped beats above must be counted.
        bus1.in_rnd_mode = 2'd0;
        bus1.in_sat_en   = 1'b1;
        repeat (2) tick();
        check_val("cnt1/after_ovf", 64'(clip_count1), 64'd4);

        // Backpressure: beat k carries (k+1).25, output (k+1)<<8 | 0x40.
        sent = 0; rcvd = 0; cyc = 0;
        m_s1 = 1'b0; m_s2 = 1'b0; have_hold = 1'b0; held = '0;
        while (rcvd < 10 && cyc < 200) begin
            bus1.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            bus1.in_valid  = (sent < 10);
            bus1.in_data   = {16'(sent + 1), 16'h4000};
            #1;
            check_val("bp/in_ready",  64'(bus1.in_ready),  64'(!(m_s1 && m_s2 && !bus1.out_ready)));
            check_val("bp/out_valid", 64'(bus1.out_valid), 64'(m_s2));
            if (have_hold) check_val("bp/stable", 64'(bus1.out_data), 64'(held));
            if (bus1.out_valid && bus1.out_ready) begin
                check_val("bp/order", 64'(bus1.out_data), 64'({8'(rcvd + 1), 8'h40}));
                rcvd++;
            end
            have_hold = bus1.out_valid && !bus1.out_ready;
            held      = bus1.out_data;
            s2l = !m_s2 || bus1.out_ready;
            s1l = !m_s1 || s2l;
            if (s1l && bus1.in_valid) sent++;
            m_s2 = s2l ? m_s1 : m_s2;
            m_s1 = s1l ? bus1.in_valid : m_s1;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (rcvd < 10) check_val("bp/timeout", 64'(rcvd), 64'd10);
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b1;
        repeat (3) tick();
        check_val("bp/no_extra", 64'(bus1.out_valid), 64'd0);

        // Reset with two beats held in the pipe.
        bus1.out_ready = 1'b0;
        bus1.in_valid  = 1'b1;
        bus1.in_data   = 32'h0080_0000;
        tick();
        bus1.in_data   = 32'h0002_0000;
        tick();
        bus1.in_valid  = 1'b0;
        check_val("mrst/full_valid", 64'(bus1.out_valid), 64'd1);
        check_val("mrst/full_ready", 64'(bus1.in_ready),  64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mrst/out_valid",  64'(bus1.out_valid), 64'd0);
        check_val("mrst/out_data",   64'(bus1.out_data),  64'd0);
        check_val("mrst/out_clip",   64'(bus1.out_clip),  64'd0);
        check_val("mrst/clip_count", 64'(clip_count1),    64'd0);
        tick();
        rst_n = 1'b1;
        bus1.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("mrst/no_stale", 64'(bus1.out_valid), 64'd0);
        end

        // Four-lane clip counter
        check_val("cnt4/reset", 64'(clip_count4), 64'd0);
        send4(4'b0011);
        tick();
        check_val("cnt4/valid", 64'(bus4.out_valid), 64'd1);
        check_val("cnt4/data",  64'(bus4.out_data),  64'h0100_0100_7FFF_7FFF);
        check_val("cnt4/clip",  64'(bus4.out_clip),  64'h3);
        send4(4'b0011);
        send4(4'b0011);
        repeat (3) tick();
        check_val("cnt4/six", 64'(clip_count4), 64'd6);

        send4(4'b0001);
        tick();
        check_val("cnt4/clr_valid", 64'(bus4.out_valid), 64'd1);
        clip_clr4 = 1'b1;
        tick();
        clip_clr4 = 1'b0;
        check_val("cnt4/clr_hs", 64'(clip_count4), 64'd1);

        clip_clr4 = 1'b1;
        tick();
        clip_clr4 = 1'b0;
        check_val("cnt4/clr_only", 64'(clip_count4), 64'd0);

        bus4.in_valid = 1'b1;
        bus4.in_data  = beat4(4'b1111);
        repeat (16383) @(posedge clk);
        #1;
        bus4.in_data  = beat4(4'b0011);
        tick();
        bus4.in_valid = 1'b0;
        repeat (3) tick();
        check_val("cnt4/fffe", 64'(clip_count4), 64'hFFFE);
        send4(4'b1111);
        repeat (3) tick();
        check_val("cnt4/sat", 64'(clip_count4), 64'hFFFF);
        send4(4'b0001);
        repeat (3) tick();
        check_val("cnt4/sat_hold", 64'(clip_count4), 64'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_resize_stream.md
# fp_resize_stream

Streaming, multi-lane signed fixed-point format converter: the parametrised successor of the combinational resize primitive in the fp_core library. Each lane converts a Q(IN_IW).(IN_QW) two's-complement value to Q(OUT_IW).(OUT_QW). The rounding mode and the saturate/wrap choice are selected per beat. The block is a 2-stage valid/ready pipeline with per-lane clip flags and a saturating clip event counter. It sits between fp_core arithmetic stages wherever precision changes.

## Interface
- IN_IW, 16: input integer bits, sign included.
- IN_QW, 16: input fraction bits.
- OUT_IW, 8: output integer bits, sign included.
- OUT_QW, 8: output fraction bits.
- LANES, 1: independent lanes per beat, ≥1. IW = IN_IW+IN_QW, OW = OUT_IW+OUT_QW.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  LANES*IW  lane i at [i*IW +: IW].
- in_rnd_mode  in  2  0 truncate (floor), 1 round half-up, 2 round half-even, 3 same as 0.
- in_sat_en  in  1  1 clamp on overflow, 0 wrap.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*OW  lane i at [i*OW +: OW].
- out_clip  out  LANES  per-lane overflow flag, qualified by out_valid.
- clip_clr  in  1  synchronous clear of clip_count.
- clip_count  out  16  saturating count of clipped lanes.

## Operation
- A beat is accepted on in_valid && in_ready. in_rnd_mode and in_sat_en are captured with the data and apply to that beat only.
- Stage 1 (align/round), with d = IN_QW − OUT_QW:
  - d ≤ 0: left shift by −d; no rounding.
  - d > 0, mode 0: arithmetic shift right by d (floor).
  - d > 0, mode 1: add 2^(d−1), then shift (ties toward +∞).
  - d > 0, mode 2: as mode 1, except on an exact tie with the kept LSB even, do not increment.
  - The intermediate result is at least IW+2 bits wide, so it cannot overflow.
- Stage 2 (range): overflow when the rounded value lies outside [−2^(OW−1), 2^(OW−1)−1].
  - out_clip[i] = overflow, regardless of in_sat_en.
  - sat_en=1: clamp to 2^(OW−1)−1 or −2^(OW−1).
  - sat_en=0: keep the low OW bits (wrap).
- Widening with no rounding overflow (OUT_IW ≥ IN_IW+1) never clips.
- clip_count:
  - On each output handshake (out_valid && out_ready), add popcount(out_clip) and saturate at 0xFFFF.
  - clip_clr has priority; if it coincides with a handshake, the new value is that beat's popcount.
- Lanes are fully independent. Only the handshake is shared.

## Timing
- Reset values: out_valid=0, out_data=0, out_clip=0, clip_count=0, both stage valids 0. in_ready=1 after reset.
- Latency: an accepted beat appears on out_valid exactly 2 cycles later if out_ready has been high.
- Throughput: 1 beat/cycle with out_ready high.
- Stage advance rules:
  - s2_load = !s2_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load (combinational from out_ready; no other comb in→out path).
- Backpressure: while out_valid && !out_ready, out_data and out_clip are held stable. At most 2 beats are buffered. No beat is dropped or duplicated.
- out_valid never drops without a handshake.
- Reset mid-operation: in-flight beats are discarded, outputs return to reset values immediately, and clip_count clears.

## Test plan
- **Basic conversion** (defaults, LANES=1, mode 0, sat 1, out_ready=1): in 0x0001_8000 (1.5) → 0x0180 two cycles later, clip=0. 0xFFFE_8000 (−1.5) → 0xFE80.
- **Rounding ties:**
  - 0x0000_0080 → mode0 0x0000, mode1 0x0001, mode2 0x0000.
  - 0x0000_0180 → mode2 0x0002.
  - 0xFFFF_FF80 → mode0 0xFFFF, mode1 0x0000, mode2 0x0000.
- **Overflow:**
  - 0x0080_0000 (128.0) → sat 0x7FFF, wrap 0x8000, clip=1 both.
  - 0xFF7F_0000 → sat 0x8000, clip=1.
  - 0x007F_FFFF with mode1, sat → 0x7FFF, clip=1 (rounding overflow).
- **Backpressure:** stream 10 beats at full rate with out_ready toggling 1,0,0,1 repeating. Outputs must be in order with no loss or duplication, data stable while stalled, in_ready=0 only when both stages are full and out_ready=0.
- **Counter** (LANES=4): 3 beats with 2 clipped lanes each → clip_count=6. Then clip_clr coincident with a 1-clip beat → 1. Force saturation from 0xFFFE with a 4-clip beat → 0xFFFF.
- **Reset mid-stream:** assert rst_n=0 with 2 beats in flight. Required: out_valid=0 immediately, clip_count=0, and no stale beat emitted after release.
